// File: rtl/powlib_busarb.sv
// powlib_busarb -- round-robin write-bus arbiter with a registered output stage.
//
// B_WRS requesters present {address, packed beat} with a valid bit. One
// requester at a time holds the grant g; only that requester sees ready.
// An accepted beat is registered and presented downstream one cycle later,
// tagged with the index of the requester that sourced it.
//
// Handshake (every port): a beat moves on a rising clk edge exactly when the
// port's valid and ready are both high. Valid may rise at any time; once a
// beat is presented on rdaddr/rddata/rdsel it holds until rdrdy takes it.
//
// Optional feature: define POWLIB_BUSARB_BURST_EN to hold a grant across up
// to B_BURST accepted beats (or until the holder drops valid). Without it
// every accepted beat releases the grant, and no beat counter exists.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wraddrs      requester addresses, slice i = [B_AW*i +: B_AW]
//   wrdatas      requester packed beats, slice i = [B_DW*i +: B_DW]
//   wrvlds       per-requester valid
//   wrrdys       per-requester ready (one-hot or zero)
//   rdaddr       arbitrated address
//   rddata       arbitrated packed beat
//   rdvld        arbitrated valid
//   rdrdy        downstream ready
//   rdsel        index of the requester that sourced rdaddr/rddata
//   dbg_state_o  FSM state, 0 = IDLE, 1 = BUSY
module powlib_busarb #(
  parameter int B_WRS   = 2,
  parameter int B_AW    = 32,
  parameter int B_DW    = 68,
  parameter int B_BURST = 4,
  parameter int SELW    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [B_AW*B_WRS-1:0]  wraddrs,
  input  logic [B_DW*B_WRS-1:0]  wrdatas,
  input  logic [B_WRS-1:0]       wrvlds,
  output logic [B_WRS-1:0]       wrrdys,
  output logic [B_AW-1:0]        rdaddr,
  output logic [B_DW-1:0]        rddata,
  output logic                   rdvld,
  input  logic                   rdrdy,
  output logic [SELW-1:0]        rdsel,
  output logic                   dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SELW-1:0]     p_q, p_d;
  logic [SELW-1:0]     g_q, g_d;
  logic                rdvld_q, rdvld_d;
  logic [B_AW-1:0]     rdaddr_q, rdaddr_d;
  logic [B_DW-1:0]     rddata_q, rddata_d;
  logic [SELW-1:0]     rdsel_q, rdsel_d;

  // Per-requester views of the flattened input buses.
  logic [B_AW-1:0]     addr_a [B_WRS];
  logic [B_DW-1:0]     data_a [B_WRS];

  for (genvar i = 0; i < B_WRS; i++) begin : g_slice
    assign addr_a[i] = wraddrs[B_AW*i +: B_AW];
    assign data_a[i] = wrdatas[B_DW*i +: B_DW];
  end

  logic [SELW-1:0]     g_inc;
  logic                slot_free;
  logic                accept;
  logic                last_beat;
  logic                new_grant;

  assign g_inc     = (g_q == SELW'(B_WRS - 1)) ? '0 : g_q + 1'b1;
  assign slot_free = !rdvld_q || rdrdy;
  assign accept    = (state_q == BUSY) && slot_free && wrvlds[g_q];

  // Round-robin search. In IDLE it starts at p; in BUSY the result is only
  // used on release, where the search starts at the post-release pointer.
  logic [SELW-1:0]     start;
  logic [2*B_WRS-1:0]  rot;
  logic [2*B_WRS-1:0]  probe;
  logic [SELW:0]       sum;
  logic                found;
  logic [SELW-1:0]     win;

  assign start = (state_q == IDLE) ? p_q : g_inc;

  always_comb begin
    rot   = {wrvlds, wrvlds} >> start;
    probe = '0;
    sum   = '0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < B_WRS; i++) begin
      probe = rot >> i;
      if (!found && probe[0]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (SELW+1)'(i);
        if (sum >= (SELW+1)'(B_WRS)) begin
          sum = sum - (SELW+1)'(B_WRS);
        end
        win = sum[SELW-1:0];
      end
    end
  end

`ifdef POWLIB_BUSARB_BURST_EN
  localparam int CNTW = (B_BURST > 1) ? $clog2(B_BURST) : 1;

  logic [CNTW-1:0] cnt_q, cnt_d;

  // The beat being accepted now is the last one the grant is allowed.
  assign last_beat = (cnt_q == CNTW'(B_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  // Grant FSM.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    p_d       = p_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d       = win;
          state_d   = BUSY;
          new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (!wrvlds[g_q] || (accept && last_beat)) begin
          // Release; the search already ran from g+1 over this cycle's
          // valids, so a sole active requester is re-granted without a gap.
          p_d = g_inc;
          if (found) begin
            g_d       = win;
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on accept, drop valid once taken, else hold.
  always_comb begin
    rdvld_d  = rdvld_q;
    rdaddr_d = rdaddr_q;
    rddata_d = rddata_q;
    rdsel_d  = rdsel_q;
    if (accept) begin
      rdvld_d  = 1'b1;
      rdaddr_d = addr_a[g_q];
      rddata_d = data_a[g_q];
      rdsel_d  = g_q;
    end else if (rdrdy) begin
      rdvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      g_q      <= '0;
      rdvld_q  <= 1'b0;
      rdaddr_q <= '0;
      rddata_q <= '0;
      rdsel_q  <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      g_q      <= g_d;
      rdvld_q  <= rdvld_d;
      rdaddr_q <= rdaddr_d;
      rddata_q <= rddata_d;
      rdsel_q  <= rdsel_d;
    end
  end

  // Ready is a function of registered state and rdrdy only.
  always_comb begin
    wrrdys = '0;
    if (state_q == BUSY && slot_free) begin
      wrrdys = B_WRS'(1) << g_q;
    end
  end

  assign rdaddr      = rdaddr_q;
  assign rddata      = rddata_q;
  assign rdvld       = rdvld_q;
  assign rdsel       = rdsel_q;
  assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_powlib_busarb.sv
// Directed testbench for powlib_busarb (B_WRS=2). Expected values are
// hand-derived from the arbitration rules; the grant pattern follows
// POWLIB_BUSARB_BURST_EN when it is defined for the build.
module tb_powlib_busarb;

  localparam int B_WRS   = 2;
  localparam int B_AW    = 32;
  localparam int B_DW    = 68;
  localparam int B_BURST = 4;
  localparam int SELW    = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [B_AW*B_WRS-1:0] wraddrs;
  logic [B_DW*B_WRS-1:0] wrdatas;
  logic [B_WRS-1:0]      wrvlds;
  logic [B_WRS-1:0]      wrrdys;
  logic [B_AW-1:0]       rdaddr;
  logic [B_DW-1:0]       rddata;
  logic                  rdvld;
  logic                  rdrdy;
  logic [SELW-1:0]       rdsel;
  logic                  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  powlib_busarb #(
    .B_WRS(B_WRS), .B_AW(B_AW), .B_DW(B_DW), .B_BURST(B_BURST), .SELW(SELW)
  ) dut (
    .clk(clk), .rst(rst), .wraddrs(wraddrs), .wrdatas(wrdatas),
    .wrvlds(wrvlds), .wrrdys(wrrdys), .rdaddr(rdaddr), .rddata(rddata),
    .rdvld(rdvld), .rdrdy(rdrdy), .rdsel(rdsel), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [B_DW-1:0] mk_data(input int r, input logic [B_AW-1:0] a);
    return {4'(r + 4'h5), ~a, a};
  endfunction

  task automatic set_req(input int r, input logic [B_AW-1:0] a);
    wraddrs[B_AW*r +: B_AW] = a;
    wrdatas[B_DW*r +: B_DW] = mk_data(r, a);
  endtask

  // Expected source of the k-th beat with both requesters always valid.
  function automatic int pat(input int k);
`ifdef POWLIB_BUSARB_BURST_EN
    return (k / B_BURST) % 2;
`else
    return k % 2;
`endif
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; rdrdy = 1'b1; wrvlds = 2'b11;
    set_req(0, 32'hDEAD0000); set_req(1, 32'hDEAD0001);
    tick; tick;
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL rst_rdvld got %0b exp 0", rdvld); end
    n_checks++; if (wrrdys !== 2'b00) begin n_fail++; $display("FAIL rst_wrrdys got %b exp 00", wrrdys); end
    n_checks++; if (rdsel !== 1'b0) begin n_fail++; $display("FAIL rst_rdsel got %0d exp 0", rdsel); end
    n_checks++; if (rdaddr !== 32'h0) begin n_fail++; $display("FAIL rst_rdaddr got %h exp 0", rdaddr); end
    n_checks++; if (rddata !== 68'h0) begin n_fail++; $display("FAIL rst_rddata got %h exp 0", rddata); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state got %0b exp 0", dbg_state); end
    rst = 1'b0; wrvlds = 2'b00;
    tick;
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL idle_state got %0b exp 0", dbg_state); end
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL idle_rdvld got %0b exp 0", rdvld); end
  endtask

  task automatic test_single;
    logic [B_DW-1:0] ed;
    ed = mk_data(1, 32'h50000010);
    set_req(1, 32'h50000010); wrvlds = 2'b10; rdrdy = 1'b1;
    #1;
    n_checks++; if (wrrdys !== 2'b00) begin n_fail++; $display("FAIL single_rdy0 got %b exp 00", wrrdys); end
    tick;
    n_checks++; if (wrrdys !== 2'b10) begin n_fail++; $display("FAIL single_rdy1 got %b exp 10", wrrdys); end
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL single_vld0 got %0b exp 0", rdvld); end
    tick;
    n_checks++; if (rdvld !== 1'b1) begin n_fail++; $display("FAIL single_vld got %0b exp 1", rdvld); end
    n_checks++; if (rdaddr !== 32'h50000010) begin n_fail++; $display("FAIL single_addr got %h exp 50000010", rdaddr); end
    n_checks++; if (rddata !== ed) begin n_fail++; $display("FAIL single_data got %h exp %h", rddata, ed); end
    n_checks++; if (rdsel !== 1'b1) begin n_fail++; $display("FAIL single_sel got %0d exp 1", rdsel); end
    wrvlds = 2'b00;
    tick;
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b exp 0", rdvld); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL single_idle got %0b exp 0", dbg_state); end
  endtask

  task automatic test_round_robin;
    logic [B_AW-1:0] base [2];
    int              seq [2];
    int              s;
    logic [B_AW-1:0] ea;
    logic [1:0]      er;
    base[0] = 32'hA0000000; base[1] = 32'hB0000000;
    seq[0] = 0; seq[1] = 0;
    set_req(0, base[0]); set_req(1, base[1]);
    wrvlds = 2'b11; rdrdy = 1'b1;
    tick;
    n_checks++; if (wrrdys !== 2'b01) begin n_fail++; $display("FAIL rr_first_rdy got %b exp 01", wrrdys); end
    for (int k = 0; k < 10; k++) begin
      tick;
      s  = pat(k);
      ea = base[s] + B_AW'(seq[s]);
      er = '0; er[pat(k + 1)] = 1'b1;
      n_checks++; if (rdvld !== 1'b1) begin n_fail++; $display("FAIL rr_vld[%0d] got %0b exp 1", k, rdvld); end
      n_checks++; if (rdsel !== SELW'(s)) begin n_fail++; $display("FAIL rr_sel[%0d] got %0d exp %0d", k, rdsel, s); end
      n_checks++; if (rdaddr !== ea) begin n_fail++; $display("FAIL rr_addr[%0d] got %h exp %h", k, rdaddr, ea); end
      n_checks++; if (wrrdys !== er) begin n_fail++; $display("FAIL rr_rdy[%0d] got %b exp %b", k, wrrdys, er); end
      seq[s]++;
      set_req(s, base[s] + B_AW'(seq[s]));
    end
    wrvlds = 2'b00;
    tick;
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %0b exp 0", rdvld); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rr_idle got %0b exp 0", dbg_state); end
  endtask

  task automatic test_backpressure;
    logic [B_DW-1:0] da;
    da = mk_data(0, 32'h12345678);
    set_req(0, 32'h12345678); wrvlds = 2'b01; rdrdy = 1'b1;
    tick; tick;
    n_checks++; if (rdaddr !== 32'h12345678) begin n_fail++; $display("FAIL bp_first got %h exp 12345678", rdaddr); end
    set_req(0, 32'h22222222); rdrdy = 1'b0;
    #1;
    n_checks++; if (wrrdys !== 2'b00) begin n_fail++; $display("FAIL bp_rdy0 got %b exp 00", wrrdys); end
    for (int k = 0; k < 5; k++) begin
      tick;
      n_checks++; if (rdvld !== 1'b1) begin n_fail++; $display("FAIL bp_vld[%0d] got %0b exp 1", k, rdvld); end
      n_checks++; if (rdaddr !== 32'h12345678) begin n_fail++; $display("FAIL bp_addr[%0d] got %h exp 12345678", k, rdaddr); end
      n_checks++; if (rddata !== da) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", k, rddata, da); end
      n_checks++; if (wrrdys !== 2'b00) begin n_fail++; $display("FAIL bp_rdy[%0d] got %b exp 00", k, wrrdys); end
    end
    rdrdy = 1'b1;
    #1;
    n_checks++; if (wrrdys !== 2'b01) begin n_fail++; $display("FAIL bp_resume_rdy got %b exp 01", wrrdys); end
    tick;
    n_checks++; if (rdvld !== 1'b1) begin n_fail++; $display("FAIL bp_b_vld got %0b exp 1", rdvld); end
    n_checks++; if (rdaddr !== 32'h22222222) begin n_fail++; $display("FAIL bp_b_addr got %h exp 22222222", rdaddr); end
    wrvlds = 2'b00;
    tick;
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b exp 0", rdvld); end
  endtask

  task automatic test_reset_mid_burst;
    set_req(0, 32'h60000000); set_req(1, 32'h70000000);
    wrvlds = 2'b10; rdrdy = 1'b1;
    tick;
    n_checks++; if (wrrdys !== 2'b10) begin n_fail++; $display("FAIL rm_grant1 got %b exp 10", wrrdys); end
    tick;
    n_checks++; if (rdaddr !== 32'h70000000) begin n_fail++; $display("FAIL rm_beat1 got %h exp 70000000", rdaddr); end
    set_req(1, 32'h70000001);
    tick;
    n_checks++; if (rdaddr !== 32'h70000001) begin n_fail++; $display("FAIL rm_beat2 got %h exp 70000001", rdaddr); end
    set_req(1, 32'h70000002);
    rst = 1'b1; wrvlds = 2'b11;
    tick;
    n_checks++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL rm_rdvld got %0b exp 0", rdvld); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rm_state got %0b exp 0", dbg_state); end
    n_checks++; if (wrrdys !== 2'b00) begin n_fail++; $display("FAIL rm_wrrdys got %b exp 00", wrrdys); end
    rst = 1'b0;
    tick;
    n_checks++; if (wrrdys !== 2'b01) begin n_fail++; $display("FAIL rm_regrant got %b exp 01", wrrdys); end
    n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL rm_busy got %0b exp 1", dbg_state); end
    tick;
    n_checks++; if (rdsel !== 1'b0) begin n_fail++; $display("FAIL rm_sel got %0d exp 0", rdsel); end
    n_checks++; if (rdaddr !== 32'h60000000) begin n_fail++; $display("FAIL rm_addr got %h exp 60000000", rdaddr); end
    wrvlds = 2'b00;
    tick; tick;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; rdrdy = 1'b1; wrvlds = '0; wraddrs = '0; wrdatas = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
